// File: rtl/traffic_pkg.sv
// Shared constants for the traffic phase scheduler: state codes, approach
// indices and lamp encodings.
package traffic_pkg;

    // FSM state codes, also driven out on the phase port
    localparam logic [2:0] ST_ALL_RED   = 3'd0;
    localparam logic [2:0] ST_GREEN_MIN = 3'd1;
    localparam logic [2:0] ST_GREEN_EXT = 3'd2;
    localparam logic [2:0] ST_YELLOW    = 3'd3;
    localparam logic [2:0] ST_PREEMPT   = 3'd4;

    // Approach indices, same bit order as req/cong
    localparam logic [1:0] DIR_NS = 2'd0;
    localparam logic [1:0] DIR_SN = 2'd1;
    localparam logic [1:0] DIR_EW = 2'd2;
    localparam logic [1:0] DIR_WE = 2'd3;

    // Per-approach lamp codes
    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

endpackage

// File: rtl/phase_timer.sv
// TW-bit down-counter: loads on request, counts down otherwise and holds at
// zero once it gets there, so an idle state can keep re-evaluating.
module phase_timer #(
    parameter int          TW      = 4,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q;

    // Load has priority; otherwise decrement and saturate at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt_q <= RST_VAL;
        else if (load_i)       cnt_q <= load_val_i;
        else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Four-approach traffic phase scheduler: round-robin green service with
// congestion extension, yellow/all-red clearance and emergency preemption.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN    = 4,
    parameter int EXT_GREEN    = 6,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int TW           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] cong,
    input  logic       emerg,
    input  logic [1:0] emerg_dir,
    output logic [7:0] light,
    output logic [2:0] phase,
    output logic [1:0] cur_dir,
    output logic       phase_done
);

    localparam logic [TW-1:0] T_AR  = TW'(ALL_RED_TIME - 1);
    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_EXT = TW'(EXT_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_TIME - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    rr_q, rr_d;
    logic          pre_q, pre_d;    // current service came from preemption
    logic [1:0]    rr_sel;
    logic [1:0]    rr_idx;
    logic          rr_hit;
    logic          zero;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;

    // First requesting approach, rotating the search start from rr_q
    always_comb begin
        rr_sel = rr_q;
        rr_hit = 1'b0;
        rr_idx = rr_q;
        for (int i = 0; i < 4; i++) begin
            rr_idx = rr_q + 2'(i);
            if (!rr_hit && req[rr_idx]) begin
                rr_sel = rr_idx;
                rr_hit = 1'b1;
            end
        end
    end

    // Next-state logic; emergency during green wins over timer expiry
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rr_d    = rr_q;
        pre_d   = pre_q;
        case (state_q)
            ST_ALL_RED: if (zero) begin
                if (emerg) begin
                    state_d = ST_PREEMPT;
                    dir_d   = emerg_dir;
                    pre_d   = 1'b1;
                end else if (|req) begin
                    state_d = ST_GREEN_MIN;
                    dir_d   = rr_sel;
                end
            end
            ST_GREEN_MIN, ST_GREEN_EXT: begin
                if (emerg) begin
                    if (emerg_dir == dir_q) begin
                        state_d = ST_PREEMPT;
                        pre_d   = 1'b1;
                    end else begin
                        state_d = ST_YELLOW;
                    end
                end else if (state_q == ST_GREEN_MIN) begin
                    if (zero) state_d = cong[dir_q] ? ST_GREEN_EXT : ST_YELLOW;
                end else if (!cong[dir_q] || zero) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: if (zero) begin
                state_d = ST_ALL_RED;
                if (!pre_q) rr_d = dir_q + 2'd1;
                pre_d   = 1'b0;
            end
            ST_PREEMPT: if (!emerg) state_d = ST_YELLOW;
            default: state_d = ST_ALL_RED;
        endcase
    end

    // Timer reloads with the new state's duration on every state change
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            ST_GREEN_MIN: tmr_val = T_MIN;
            ST_GREEN_EXT: tmr_val = T_EXT;
            ST_YELLOW:    tmr_val = T_YEL;
            ST_PREEMPT:   tmr_val = '0;
            default:      tmr_val = T_AR;
        endcase
    end

    phase_timer #(.TW(TW), .RST_VAL(T_AR)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (zero)
    );

    // State, served direction, round-robin pointer and preempt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ALL_RED;
            dir_q   <= DIR_NS;
            rr_q    <= DIR_NS;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rr_q    <= rr_d;
            pre_q   <= pre_d;
        end
    end

    // Moore lamp decode; reset forces ALL_RED so all lamps go red at once
    always_comb begin
        light = '0;
        case (state_q)
            ST_GREEN_MIN, ST_GREEN_EXT, ST_PREEMPT: light[{dir_q, 1'b0} +: 2] = LAMP_GREEN;
            ST_YELLOW:                              light[{dir_q, 1'b0} +: 2] = LAMP_YELLOW;
            default:                                light = '0;
        endcase
    end

    assign phase      = state_q;
    assign cur_dir    = dir_q;
    assign phase_done = (state_q == ST_YELLOW) && zero;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default timing parameters.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] cong;
    logic       emerg;
    logic [1:0] emerg_dir;
    logic [7:0] light;
    logic [2:0] phase;
    logic [1:0] cur_dir;
    logic       phase_done;

    int total = 0;
    int bad   = 0;

    traffic_phase_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .cong       (cong),
        .emerg      (emerg),
        .emerg_dir  (emerg_dir),
        .light      (light),
        .phase      (phase),
        .cur_dir    (cur_dir),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] l, input logic [2:0] ph,
                       input logic [1:0] d, input logic pd);
        logic [13:0] got, exp;
        got = {light, phase, cur_dir, phase_done};
        exp = {l, ph, d, pd};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got light=%h phase=%0d dir=%0d done=%b, exp light=%h phase=%0d dir=%0d done=%b",
                   tag, light, phase, cur_dir, phase_done, l, ph, d, pd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] g(input int d);
        return 8'h01 << (2 * d);
    endfunction

    function automatic logic [7:0] y(input int d);
        return 8'h02 << (2 * d);
    endfunction

    task automatic greens(input string tag, input int d, input int n, input logic [2:0] ph);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, g(d), ph, 2'(d), 1'b0);
        end
    endtask

    task automatic yellows(input string tag, input int d);
        tick(); chk(tag, y(d), 3'd3, 2'(d), 1'b0);
        tick(); chk(tag, y(d), 3'd3, 2'(d), 1'b1);
    endtask

    task automatic allred(input string tag, input int d);
        tick(); chk(tag, 8'h00, 3'd0, 2'(d), 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; cong = 4'b0; emerg = 1'b0; emerg_dir = 2'd0;
        #3;
        chk("reset_async", 8'h00, 3'd0, 2'd0, 1'b0);
        tick();
        chk("reset_hold", 8'h00, 3'd0, 2'd0, 1'b0);
        rst = 1'b0;
        req = 4'b0001;

        // single requester: NS 4 green, 2 yellow, 1 all red, NS again
        greens("ns_green", 0, 4, 3'd1);
        yellows("ns_yellow", 0);
        allred("ns_allred", 0);
        greens("ns_regrant", 0, 1, 3'd1);

        // all requesting: NS, SN, EW, WE, NS
        req = 4'b1111;
        greens("rr_ns", 0, 3, 3'd1); yellows("rr_ns_y", 0); allred("rr_ns_r", 0);
        greens("rr_sn", 1, 4, 3'd1); yellows("rr_sn_y", 1); allred("rr_sn_r", 1);
        greens("rr_ew", 2, 4, 3'd1); yellows("rr_ew_y", 2); allred("rr_ew_r", 2);
        greens("rr_we", 3, 4, 3'd1); yellows("rr_we_y", 3); allred("rr_we_r", 3);
        greens("rr_ns2", 0, 4, 3'd1); yellows("rr_ns2_y", 0);
        allred("rr_ns2_r", 0);

        // congestion held: 4 min + 6 extension
        req = 4'b0001; cong = 4'b0001;
        greens("cong_min", 0, 4, 3'd1);
        greens("cong_ext", 0, 6, 3'd2);
        yellows("cong_y", 0); allred("cong_r", 0);
        // congestion drops in extension cycle 2
        greens("cdrop_min", 0, 4, 3'd1);
        greens("cdrop_ext", 0, 2, 3'd2);
        cong = 4'b0000;
        yellows("cdrop_y", 0); allred("cdrop_r", 0);

        // emergency to EW while NS is green
        greens("em_ns", 0, 2, 3'd1);
        emerg = 1'b1; emerg_dir = 2'd2;
        yellows("em_ns_y", 0);
        allred("em_allred", 0);
        greens("em_pre", 2, 5, 3'd4);
        emerg = 1'b0;
        yellows("em_ew_y", 2); allred("em_ew_r", 2);
        req = 4'b1111;
        greens("em_after_sn", 1, 4, 3'd1);
        yellows("sn_y", 1); allred("sn_r", 1);
        greens("ew_g", 2, 4, 3'd1);

        // reset pulse during EW yellow
        tick();
        chk("ew_yellow", y(2), 3'd3, 2'd2, 1'b0);
        #2 rst = 1'b1;
        #1 chk("mid_reset", 8'h00, 3'd0, 2'd0, 1'b0);
        rst = 1'b0;
        greens("post_rst_ns", 0, 4, 3'd1);
        yellows("post_rst_y", 0); allred("post_rst_r", 0);

        // no requests: idle in ALL_RED
        req = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", 8'h00, 3'd0, 2'd0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
